// File: rtl/tdm_demux_1to8.sv
// ---------------------------------------------------------------------------
// tdm_demux_1to8
// Time-division 1-to-N demultiplexer. This block is the receive side of the
// 8-to-1 channel mux. It collects one channel word per accepted slot, with
// channel 0 first. When the last slot arrives it presents the whole frame as
// one registered parallel word. It also drives the slot index back to the
// upstream mux select, so both ends walk the same slot sequence.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   din          slot data word
//   din_valid    qualifies din and frame_start; one slot is accepted per cycle
//   frame_start  marks the channel-0 word of a frame
//   sel          slot index of the next expected word (to the mux select)
//   dout         last complete frame; dout[c*DATA_W +: DATA_W] is channel c
//   frame_valid  one-cycle pulse when dout is updated
//   sync_err     one-cycle pulse on a frame-alignment error
//
// State | meaning
// ------+------------------------------------------------------------
// IDLE  | not aligned; waiting for a frame_start word
// RUN   | aligned; slot holds the index of the next expected channel
// ---------------------------------------------------------------------------
module tdm_demux_1to8 #(
    parameter int NUM_CH = 8,
    parameter int DATA_W = 1,
    parameter int SEL_W  = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_W-1:0]        din,
    input  logic                     din_valid,
    input  logic                     frame_start,
    output logic [SEL_W-1:0]         sel,
    output logic [NUM_CH*DATA_W-1:0] dout,
    output logic                     frame_valid,
    output logic                     sync_err
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int                SH_W      = (NUM_CH - 1) * DATA_W;
    localparam logic [SEL_W-1:0]  LAST_SLOT = SEL_W'(NUM_CH - 1);

    state_t                   state, state_nxt;
    logic [SEL_W-1:0]         slot, slot_nxt;
    // The last channel never lands in the shadow register. It goes straight
    // into dout together with the stored channels 0..NUM_CH-2.
    logic [SH_W-1:0]          shadow, shadow_nxt;
    logic [NUM_CH*DATA_W-1:0] dout_nxt;
    logic                     frame_valid_nxt;
    logic                     sync_err_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            slot        <= '0;
            shadow      <= '0;
            dout        <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            state       <= state_nxt;
            slot        <= slot_nxt;
            shadow      <= shadow_nxt;
            dout        <= dout_nxt;
            frame_valid <= frame_valid_nxt;
            sync_err    <= sync_err_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        slot_nxt        = slot;
        shadow_nxt      = shadow;
        dout_nxt        = dout;
        frame_valid_nxt = 1'b0;
        sync_err_nxt    = 1'b0;

        unique case (state)
            IDLE: begin
                if (din_valid && frame_start) begin
                    shadow_nxt[0 +: DATA_W] = din;
                    slot_nxt                = SEL_W'(1);
                    state_nxt               = RUN;
                end
            end

            RUN: begin
                if (din_valid) begin
                    if (frame_start) begin
                        // A start word away from slot 0 drops the partial
                        // frame. The word is still kept as channel 0 of the
                        // new frame.
                        sync_err_nxt            = (slot != '0);
                        shadow_nxt[0 +: DATA_W] = din;
                        slot_nxt                = SEL_W'(1);
                    end else if (slot == '0) begin
                        // A non-start word arrived where a start word was
                        // expected. The word is dropped and alignment is lost.
                        sync_err_nxt = 1'b1;
                        state_nxt    = IDLE;
                    end else if (slot == LAST_SLOT) begin
                        dout_nxt        = {din, shadow};
                        frame_valid_nxt = 1'b1;
                        slot_nxt        = '0;
                    end else begin
                        for (int c = 1; c < NUM_CH - 1; c++) begin
                            if (slot == SEL_W'(c)) begin
                                shadow_nxt[c*DATA_W +: DATA_W] = din;
                            end
                        end
                        slot_nxt = slot + SEL_W'(1);
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
                slot_nxt  = '0;
            end
        endcase
    end

    assign sel = slot;

endmodule

// File: tb/tb_tdm_demux_1to8.sv
module tb_tdm_demux_1to8;

    logic       clk;
    logic       rst_n;
    logic [0:0] din;
    logic       din_valid;
    logic       frame_start;
    logic [2:0] sel;
    logic [7:0] dout;
    logic       frame_valid;
    logic       sync_err;

    int checks   = 0;
    int failures = 0;
    int fv_cnt   = 0;
    int se_cnt   = 0;

    tdm_demux_1to8 #(.NUM_CH(8), .DATA_W(1), .SEL_W(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .din_valid   (din_valid),
        .frame_start (frame_start),
        .sel         (sel),
        .dout        (dout),
        .frame_valid (frame_valid),
        .sync_err    (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs are driven at a falling edge. The rising edge samples them, and
    // the outputs are then observed at the next falling edge.
    task automatic step(input logic v, input logic fs, input logic d);
        din_valid   = v;
        frame_start = fs;
        din         = d;
        @(posedge clk);
        @(negedge clk);
        if (frame_valid) fv_cnt++;
        if (sync_err)    se_cnt++;
        din_valid   = 1'b0;
        frame_start = 1'b0;
    endtask

    // Sends a full frame with no gaps. It checks sel before every word and
    // checks that frame_valid goes high only after the last word.
    task automatic send_frame(input logic [7:0] pat, input string tag);
        for (int i = 0; i < 8; i++) begin
            check_eq({tag, "_sel"}, 32'(sel), 32'(i));
            step(1'b1, i == 0, pat[i]);
            check_eq({tag, "_fv"}, 32'(frame_valid), 32'(i == 7));
        end
        check_eq({tag, "_dout"}, 32'(dout), 32'(pat));
        check_eq({tag, "_sel_wrap"}, 32'(sel), 32'd0);
    endtask

    logic [7:0] pat;
    int         gap;
    int         fv_base;
    int         se_base;

    initial begin
        rst_n       = 1'b0;
        din         = 1'b0;
        din_valid   = 1'b0;
        frame_start = 1'b0;
        @(negedge clk);
        check_eq("rst_sel",  32'(sel),         32'd0);
        check_eq("rst_dout", 32'(dout),        32'd0);
        check_eq("rst_fv",   32'(frame_valid), 32'd0);
        check_eq("rst_se",   32'(sync_err),    32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // T2: a single frame, ch0..ch7 = 1,0,1,1,0,0,1,0 -> 8'h4D
        se_base = se_cnt;
        send_frame(8'h4D, "t2");
        step(1'b0, 1'b0, 1'b0);
        check_eq("t2_fv_once", 32'(frame_valid), 32'd0);

        // T3: the same frame, with 0-3 idle cycles between words
        fv_base = fv_cnt;
        pat = 8'h4D;
        for (int i = 0; i < 8; i++) begin
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                step(1'b0, 1'b1, 1'b1);
                check_eq("t3_sel_gap", 32'(sel), 32'(i));
            end
            step(1'b1, i == 0, pat[i]);
        end
        check_eq("t3_dout", 32'(dout), 32'h4D);
        check_eq("t3_fv_cnt", 32'(fv_cnt - fv_base), 32'd1);
        check_eq("t3_se_cnt", 32'(se_cnt - se_base), 32'd0);

        // T4: frame_start again at slot 5; the new frame is 8'h3C
        for (int i = 0; i < 5; i++) step(1'b1, i == 0, 1'b1);
        check_eq("t4_sel5", 32'(sel), 32'd5);
        pat = 8'h3C;
        step(1'b1, 1'b1, pat[0]);
        check_eq("t4_se",   32'(sync_err),    32'd1);
        check_eq("t4_dout", 32'(dout),        32'h4D);
        check_eq("t4_sel",  32'(sel),         32'd1);
        check_eq("t4_fv",   32'(frame_valid), 32'd0);
        for (int i = 1; i < 8; i++) begin
            step(1'b1, 1'b0, pat[i]);
            if (i == 1) check_eq("t4_se_pulse", 32'(sync_err), 32'd0);
        end
        check_eq("t4_fv_new",   32'(frame_valid), 32'd1);
        check_eq("t4_dout_new", 32'(dout),        32'h3C);

        // T5: a non-start word at slot 0 sends the block to IDLE
        step(1'b1, 1'b0, 1'b1);
        check_eq("t5_se",  32'(sync_err), 32'd1);
        check_eq("t5_sel", 32'(sel),      32'd0);
        fv_base = fv_cnt;
        se_base = se_cnt;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1);
        check_eq("t5_fv_cnt", 32'(fv_cnt - fv_base), 32'd0);
        check_eq("t5_se_cnt", 32'(se_cnt - se_base), 32'd0);
        check_eq("t5_sel_idle", 32'(sel),  32'd0);
        check_eq("t5_dout",     32'(dout), 32'h3C);

        // T6: back-to-back frames 8'hA5 then 8'h3C
        se_base = se_cnt;
        for (int i = 0; i < 16; i++) begin
            pat = (i < 8) ? 8'hA5 : 8'h3C;
            check_eq("t6_sel", 32'(sel), 32'(i % 8));
            step(1'b1, (i % 8) == 0, pat[i % 8]);
            check_eq("t6_fv", 32'(frame_valid), 32'((i % 8) == 7));
            if (i == 7)  check_eq("t6_dout_a", 32'(dout), 32'hA5);
            if (i == 15) check_eq("t6_dout_b", 32'(dout), 32'h3C);
        end
        check_eq("t6_se_cnt", 32'(se_cnt - se_base), 32'd0);

        // T1: reset in the middle of a frame, at slot 4
        for (int i = 0; i < 4; i++) step(1'b1, i == 0, 1'b1);
        check_eq("t1_sel4", 32'(sel), 32'd4);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t1_sel",  32'(sel),         32'd0);
        check_eq("t1_dout", 32'(dout),        32'd0);
        check_eq("t1_fv",   32'(frame_valid), 32'd0);
        check_eq("t1_se",   32'(sync_err),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        fv_base = fv_cnt;
        se_base = se_cnt;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 1'b1);
            check_eq("t1_sel_ign", 32'(sel), 32'd0);
        end
        check_eq("t1_fv_cnt", 32'(fv_cnt - fv_base), 32'd0);
        check_eq("t1_se_cnt", 32'(se_cnt - se_base), 32'd0);
        send_frame(8'h4D, "t1_after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
